rr_arb16: RTL and testbench
===========================

RR_ARB16 -- requirements
Module: rr_arb16

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 16, giving the maximum consecutive cycles one owner may hold the grant (legal range 2..31).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state changes on its rising edge.
REQ-003 The block SHALL have port clr, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port req, input, 16 bits: request vector, bit i = requester i wants the shared resource.
REQ-005 The block SHALL have port rel, input, 1 bit: current owner releases the resource this cycle.
REQ-006 The block SHALL have port gnt, output, 16 bits: one-hot grant, or zero when no owner.
REQ-007 The block SHALL have port gnt_id, output, 4 bits: binary index of the current owner, valid when gnt_v=1.
REQ-008 The block SHALL have port gnt_v, output, 1 bit: some requester currently owns the resource.
REQ-009 The block SHALL have port tmo, output, 1 bit: one-cycle pulse, owner forcibly released by hold timeout.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner = gnt_id).
REQ-011 The block SHALL keep a 4-bit pointer ptr equal to the last granted index.
REQ-012 Arbitration SHALL select the lowest set index of req masked to indices strictly greater than ptr; if that masked vector is empty, it SHALL select the lowest set index of unmasked req.
REQ-013 In IDLE with req≠0, the block SHALL enter BUSY at the next edge with gnt_v=1, gnt_id=winner, gnt=one-hot(winner), ptr=winner, hold counter=1 (one-cycle grant latency).
REQ-014 In IDLE with req=0, all outputs SHALL hold at zero.
REQ-015 In BUSY, the release condition SHALL be rel=1, OR req[gnt_id]=0, OR hold counter=HOLD_MAX.
REQ-016 In BUSY without the release condition, grant outputs SHALL be unchanged, and the hold counter SHALL increment by 1 (5-bit, saturating at HOLD_MAX).
REQ-017 In BUSY with the release condition and the arbitration winner present, the block SHALL grant that winner at the next edge with no idle cycle (back-to-back handoff); the current owner wins again only if it is the sole requester and its request is still asserted.
REQ-018 In BUSY with the release condition and no winner, the block SHALL return to IDLE at the next edge with gnt=0, gnt_v=0, and gnt_id holding its last value.
REQ-019 tmo SHALL be 1 for exactly the cycle after a release caused solely by counter=HOLD_MAX (rel=0 and req[gnt_id]=1); otherwise tmo SHALL be 0.
REQ-020 A timed-out owner that is the sole requester SHALL be re-granted, with the counter restarting at 1.
REQ-021 gnt SHALL always be zero or one-hot, and gnt SHALL equal one-hot(gnt_id) whenever gnt_v=1.
REQ-022 All outputs SHALL be driven directly from flops, with no combinational path from req or rel to any output.

Reset
REQ-023 While clr=0, the block SHALL asynchronously force: state=IDLE, gnt=0, gnt_id=0, gnt_v=0, tmo=0, hold counter=0, ptr=15 (so the first search starts at index 0).
REQ-024 Reset asserted mid-grant SHALL drop the grant immediately, without waiting for a clock.
REQ-025 After clr rises, the first arbitration SHALL occur at the first clk edge.

Structure
REQ-026 State encodings (IDLE, BUSY), the requester count (16), and the default HOLD_MAX SHALL live in a shared arbiter constants include.
REQ-027 Arbitration SHALL use two instances of the existing lowest-index priority encoder per16_4 (masked and unmasked), selected by the masked encoder's valid output.
REQ-028 The mask, rotation, FSM, and counter logic SHALL remain inside rr_arb16, with no further sub-modules.

Verification
REQ-029 Reset then req=16'h0000 for 5 cycles -> gnt=0, gnt_v=0, tmo=0 throughout.
REQ-030 req=16'h8001 held with rel pulsed every 3rd cycle -> owners alternate 0,15,0,15 with no idle cycle between owners.
REQ-031 req=16'h0124 and owner 2 releases -> next owner 5; owner 5 releases -> 8; owner 8 releases -> 2 (wrap-around).
REQ-032 req=16'h0010 held, rel=0, HOLD_MAX=16 -> tmo pulses once after 16 BUSY cycles, owner 4 is re-granted, counter=1.
REQ-033 req=16'h0003, owner 0 drops req[0] without rel -> owner 1 at the next edge; then req=0 -> IDLE, gnt_v=0.
REQ-034 clr pulsed low mid-grant, asynchronous to clk -> gnt=0 and gnt_v=0 before the next edge; after release, req=16'h8000 -> owner 15 (ptr=15 mask empty, unmasked fallback).

Source files
------------

// File: rtl/rr_arb16_pkg.sv
// Shared arbiter constants: requester count, default hold limit, FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package rr_arb16_pkg;

    localparam int NREQ         = 16;
    localparam int IDX_W        = 4;
    localparam int HOLD_MAX_DEF = 16;
    localparam int CNT_W        = 5;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage : rr_arb16_pkg

// File: rtl/rr_arb16_per16_4.sv
// Lowest-index priority encoder, 16 inputs to 4-bit binary index.
// Latency: purely combinational.
// Backpressure: none; vld_o=0 and idx_o=0 when no input bit is set.
//   req_i [15:0] : candidate vector
//   idx_o [3:0]  : index of the lowest set bit
//   vld_o        : at least one bit of req_i is set
module per16_4 (
    input  logic [15:0] req_i,
    output logic [3:0]  idx_o,
    output logic        vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = |req_i;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 15; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = 4'(i);
            end
        end
    end

endmodule : per16_4

// File: rtl/rr_arb16.sv
// Round-robin arbiter for 16 requesters with a bounded hold time per owner.
// Latency: one cycle from request to grant; back-to-back handoff on release.
// Backpressure: owner holds until rel, request drop, or HOLD_MAX cycles (tmo pulse).
//   clk, clr     : clock, asynchronous active-low reset
//   req [15:0]   : request vector
//   rel          : current owner releases this cycle
//   gnt [15:0]   : one-hot grant (zero when idle)
//   gnt_id [3:0] : index of current owner, valid while gnt_v=1
//   gnt_v        : resource currently owned
//   tmo          : one-cycle pulse after a hold-timeout release
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [NREQ-1:0]   req,
    input  logic              rel,
    output logic [NREQ-1:0]   gnt,
    output logic [IDX_W-1:0]  gnt_id,
    output logic              gnt_v,
    output logic              tmo
);

    arb_state_e         state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tmo_q, tmo_d;

    logic [NREQ-1:0]    req_msk;
    logic [IDX_W-1:0]   msk_idx, raw_idx, win_idx;
    logic               msk_vld, raw_vld;
    logic               hold_max_hit;
    logic               rel_cond;

    // Only indices strictly above the last grant are eligible on the first pass.
    always_comb begin
        req_msk = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i > int'(ptr_q)) begin
                req_msk[i] = req[i];
            end
        end
    end

    per16_4 u_enc_msk (
        .req_i (req_msk),
        .idx_o (msk_idx),
        .vld_o (msk_vld)
    );

    per16_4 u_enc_raw (
        .req_i (req),
        .idx_o (raw_idx),
        .vld_o (raw_vld)
    );

    // Wrap around to the unmasked search when nothing lies above the pointer.
    assign win_idx      = msk_vld ? msk_idx : raw_idx;
    assign hold_max_hit = (cnt_q == CNT_W'(HOLD_MAX));
    assign rel_cond     = rel | ~req[gnt_id_q] | hold_max_hit;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (raw_vld) begin
                    state_d  = BUSY;
                    gnt_d    = NREQ'(1) << win_idx;
                    gnt_id_d = win_idx;
                    ptr_d    = win_idx;
                    cnt_d    = CNT_W'(1);
                end
            end
            BUSY: begin
                if (rel_cond) begin
                    // Timeout is flagged only when nothing else explains the release.
                    tmo_d = hold_max_hit & ~rel & req[gnt_id_q];
                    if (raw_vld) begin
                        gnt_d    = NREQ'(1) << win_idx;
                        gnt_id_d = win_idx;
                        ptr_d    = win_idx;
                        cnt_d    = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (!hold_max_hit) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= IDX_W'(NREQ - 1);
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign gnt_v  = (state_q == BUSY);
    assign tmo    = tmo_q;

endmodule : rr_arb16

// File: tb/tb_rr_arb16.sv
module tb_rr_arb16;

    localparam int HM = 16;

    logic        clk;
    logic        clr;
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        gnt_v;
    logic        tmo;

    rr_arb16 #(.HOLD_MAX(HM)) dut (
        .clk    (clk),
        .clr    (clr),
        .req    (req),
        .rel    (rel),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .gnt_v  (gnt_v),
        .tmo    (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] g;
        logic [3:0]  id;
        logic        t;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    bit   check_en = 1'b0;

    // Reference model: owner index (-1 = none), last granted index, cycles held.
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_tmo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic int rr_pick(input logic [15:0] r, input int last);
        for (int k = 1; k <= 16; k++) begin
            if (r[(last + k) % 16]) return (last + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 15;
        m_cnt   = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step(input logic [15:0] r, input logic l);
        int  w;
        bit  give_up;
        m_tmo = 1'b0;
        w = rr_pick(r, m_ptr);
        if (m_owner < 0) begin
            if (w >= 0) begin
                m_owner = w; m_ptr = w; m_cnt = 1;
            end
        end else begin
            give_up = l || !r[m_owner] || (m_cnt == HM);
            if (give_up) begin
                m_tmo = (m_cnt == HM) && !l && r[m_owner];
                if (w >= 0) begin
                    m_owner = w; m_ptr = w; m_cnt = 1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic [15:0] r, input logic l);
        exp_t e;
        @(negedge clk);
        req = r;
        rel = l;
        model_step(r, l);
        e.v  = (m_owner >= 0);
        e.g  = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        e.id = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
        e.t  = m_tmo;
        exp_q.push_back(e);
        check_en = 1'b1;
    endtask

    // Pulses clr low between edges and checks the grant drops without a clock.
    task automatic async_reset();
        @(negedge clk);
        check_en = 1'b0;
        exp_q.delete();
        #2 clr = 1'b0;
        #1;
        chk("async_gnt",   32'(gnt),   32'd0);
        chk("async_gnt_v", 32'(gnt_v), 32'd0);
        chk("async_tmo",   32'(tmo),   32'd0);
        repeat (2) @(negedge clk);
        req = '0;
        rel = 1'b0;
        clr = 1'b1;
        model_reset();
    endtask

    // Monitor: every cycle the DUT presents a state, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (check_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL scoreboard_empty: no expectation queued at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt_v", 32'(gnt_v), 32'(e.v));
                    chk("gnt",   32'(gnt),   32'(e.g));
                    if (e.v) chk("gnt_id", 32'(gnt_id), 32'(e.id));
                    chk("tmo",   32'(tmo),   32'(e.t));
                end
            end
        end
    end

    initial begin
        logic [15:0] rq;
        logic        rl;
        req = '0;
        rel = 1'b0;
        clr = 1'b0;
        model_reset();
        #12;
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_gnt_v", 32'(gnt_v), 32'd0);
        chk("rst_tmo",   32'(tmo),   32'd0);
        @(negedge clk);
        clr = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) step(16'h0000, 1'b0);

        // Two far-apart requesters, release every third cycle: 0,15,0,15.
        for (int i = 0; i < 12; i++) step(16'h8001, (i % 3) == 2);
        step(16'h0000, 1'b0);

        // Wrap-around rotation 2 -> 5 -> 8 -> 2.
        for (int i = 0; i < 8; i++) step(16'h0124, (i % 2) == 1);
        step(16'h0000, 1'b0);
        step(16'h0000, 1'b0);

        // Sole requester held past HOLD_MAX: timeout pulse and re-grant.
        for (int i = 0; i < 40; i++) step(16'h0010, 1'b0);
        step(16'h0000, 1'b0);

        // Owner drops its request: handoff, then idle.
        step(16'h0003, 1'b0);
        step(16'h0003, 1'b0);
        step(16'h0002, 1'b0);
        step(16'h0002, 1'b0);
        step(16'h0000, 1'b0);
        step(16'h0000, 1'b0);

        // Reset mid-grant, then a lone request at index 15.
        step(16'h0040, 1'b0);
        step(16'h0040, 1'b0);
        async_reset();
        for (int i = 0; i < 3; i++) step(16'h8000, 1'b0);
        step(16'h0000, 1'b0);

        // Randomized traffic with sticky request vectors so timeouts occur.
        rq = 16'h0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rq = 16'h0000;
                    1:       rq = 16'(1) << $urandom_range(0, 15);
                    default: rq = 16'($urandom) & 16'($urandom);
                endcase
            end
            rl = ($urandom_range(0, 9) == 0);
            step(rq, rl);
        end

        step(16'h0000, 1'b0);
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_rr_arb16
